// File: rtl/cu_pkg.sv
// Shared encodings for the control unit: opcodes, register addresses,
// ALU operation codes, FSM states and the control word layout.
package cu_pkg;

  localparam logic [4:0] OP_NOP    = 5'b00000;
  localparam logic [4:0] OP_LD_DIR = 5'b00001;
  localparam logic [4:0] OP_ST_DIR = 5'b00010;
  localparam logic [4:0] OP_LD_IMM = 5'b00011;
  localparam logic [4:0] OP_ADD    = 5'b00100;
  localparam logic [4:0] OP_SUB    = 5'b00101;
  localparam logic [4:0] OP_AND    = 5'b00110;
  localparam logic [4:0] OP_OR     = 5'b00111;
  localparam logic [4:0] OP_JZ     = 5'b01000;
  localparam logic [4:0] OP_JC     = 5'b01001;
  localparam logic [4:0] OP_HALT   = 5'b11111;

  localparam logic [2:0] REG_PC   = 3'd0;
  localparam logic [2:0] REG_DPTR = 3'd1;
  localparam logic [2:0] REG_A    = 3'd2;
  localparam logic [2:0] REG_TEMP = 3'd3;
  localparam logic [2:0] REG_ACC  = 3'd7;

  localparam logic [2:0] ALU_PASS_B = 3'b000;
  localparam logic [2:0] ALU_ADD    = 3'b001;
  localparam logic [2:0] ALU_SUB    = 3'b010;
  localparam logic [2:0] ALU_AND    = 3'b011;
  localparam logic [2:0] ALU_OR     = 3'b100;
  localparam logic [2:0] ALU_SHL    = 3'b101;
  localparam logic [2:0] ALU_INC_B  = 3'b110;
  localparam logic [2:0] ALU_DEC_B  = 3'b111;

  typedef enum logic [3:0] {
    S_INIT, S_F0, S_F1, S_F2, S_DEC,
    S_E0, S_E1, S_E2, S_E3, S_E4, S_HALT
  } state_t;

  typedef struct packed {
    logic       ir_sclr;
    logic       mar_sclr;
    logic       enaf;
    logic [2:0] selop;
    logic [1:0] shamt;
    logic       bank_wr_en;
    logic [2:0] busB_addr;
    logic [2:0] busC_addr;
    logic       ir_en;
    logic       mar_en;
    logic       mdr_en;
    logic       wr_rdn;
    logic       mdr_alu_n;
    logic       halted;
    logic       illegal;
  } ctrl_t;

  function automatic logic opc_is_alu(input logic [4:0] op);
    return op[4:2] == 3'b001;
  endfunction

  function automatic logic opc_legal(input logic [4:0] op);
    return (op <= OP_JC) || (op == OP_HALT);
  endfunction

  // ADD/SUB/AND/OR occupy consecutive opcodes and consecutive selop codes
  function automatic logic [2:0] opc_alu_sel(input logic [4:0] op);
    return {1'b0, op[1:0]} + 3'd1;
  endfunction

endpackage

// File: rtl/cu_decode.sv
// Combinational control-word decode from FSM state, latched opcode and flags.
module cu_decode
  import cu_pkg::*;
#(
  parameter int OPC_W = 5
) (
  input  state_t           state,
  input  logic [OPC_W-1:0] op,
  input  logic [OPC_W-1:0] instruction,
  input  logic             c,
  input  logic             z,
  output ctrl_t            ctrl
);

  logic is_dir;
  assign is_dir = (op == OP_LD_DIR) || (op == OP_ST_DIR);

  always_comb begin
    ctrl = '0;
    case (state)
      S_INIT: begin
        ctrl.ir_sclr  = 1'b1;
        ctrl.mar_sclr = 1'b1;
      end
      S_F0: ctrl.mar_en = 1'b1;
      S_F1, S_E1: begin
        ctrl.mdr_en     = 1'b1;
        ctrl.selop      = ALU_INC_B;
        ctrl.bank_wr_en = 1'b1;
        ctrl.busB_addr  = REG_PC;
        ctrl.busC_addr  = REG_PC;
      end
      S_F2:  ctrl.ir_en   = 1'b1;
      S_DEC: ctrl.illegal = !opc_legal(instruction);
      S_E0: begin
        if (opc_is_alu(op)) begin
          ctrl.bank_wr_en = 1'b1;
          ctrl.busB_addr  = REG_A;
          ctrl.busC_addr  = REG_ACC;
          ctrl.selop      = opc_alu_sel(op);
          ctrl.enaf       = 1'b1;
        end else begin
          ctrl.mar_en = 1'b1;
        end
      end
      S_E2: begin
        if (is_dir) begin
          ctrl.mar_en    = 1'b1;
          ctrl.mdr_alu_n = 1'b1;
        end else if (op == OP_LD_IMM) begin
          ctrl.bank_wr_en = 1'b1;
          ctrl.busC_addr  = REG_ACC;
          ctrl.mdr_alu_n  = 1'b1;
        end else if ((op == OP_JZ && z) || (op == OP_JC && c)) begin
          ctrl.bank_wr_en = 1'b1;
          ctrl.busC_addr  = REG_PC;
          ctrl.mdr_alu_n  = 1'b1;
        end
      end
      S_E3: begin
        ctrl.mdr_en = 1'b1;
        if (op == OP_ST_DIR) begin
          ctrl.busB_addr = REG_ACC;
          ctrl.selop     = ALU_PASS_B;
        end
      end
      S_E4: begin
        if (op == OP_ST_DIR) begin
          ctrl.wr_rdn = 1'b1;
        end else begin
          ctrl.bank_wr_en = 1'b1;
          ctrl.busC_addr  = REG_ACC;
          ctrl.mdr_alu_n  = 1'b1;
        end
      end
      S_HALT:  ctrl.halted = 1'b1;
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Moore fetch/decode/execute sequencer driving memory_system control inputs.
//   state | meaning
//   INIT  | clear IR and MAR
//   F0-F2 | MAR<-PC, MDR<-mem & PC++, IR<-MDR
//   DEC   | sample opcode, flag illegal
//   E0-E4 | execute (E0/E1 double as operand fetch)
//   HALT  | idle until start
module control_unit
  import cu_pkg::*;
#(
  parameter int OPC_W     = 5,
  parameter bit RST_FETCH = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [OPC_W-1:0] instruction,
  input  logic             C,
  input  logic             N,
  input  logic             P,
  input  logic             Z,
  output logic             ir_sclr,
  output logic             mar_sclr,
  output logic             enaf,
  output logic [2:0]       selop,
  output logic [1:0]       shamt,
  output logic             bank_wr_en,
  output logic [2:0]       busB_addr,
  output logic [2:0]       busC_addr,
  output logic             ir_en,
  output logic             mar_en,
  output logic             mdr_en,
  output logic             wr_rdn,
  output logic             mdr_alu_n,
  output logic             halted,
  output logic             illegal
);

  state_t           state;
  logic [OPC_W-1:0] op_q;
  ctrl_t            ctrl;

  // N and P are carried for future conditional branches
  logic unused_flags;
  assign unused_flags = N ^ P;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_INIT;
      op_q  <= '0;
    end else begin
      case (state)
        S_INIT: state <= RST_FETCH ? S_F0 : S_HALT;
        S_F0:   state <= S_F1;
        S_F1:   state <= S_F2;
        S_F2:   state <= S_DEC;
        S_DEC: begin
          op_q <= instruction;
          if (instruction == OP_HALT)
            state <= S_HALT;
          else if (opc_legal(instruction) && instruction != OP_NOP)
            state <= S_E0;
          else
            state <= S_F0;
        end
        S_E0:   state <= opc_is_alu(op_q) ? S_F0 : S_E1;
        S_E1:   state <= S_E2;
        S_E2:   state <= (op_q == OP_LD_DIR || op_q == OP_ST_DIR) ? S_E3 : S_F0;
        S_E3:   state <= S_E4;
        S_E4:   state <= S_F0;
        S_HALT: if (start) state <= S_F0;
        default: state <= S_INIT;
      endcase
    end
  end

  cu_decode #(.OPC_W(OPC_W)) u_decode (
    .state       (state),
    .op          (op_q),
    .instruction (instruction),
    .c           (C),
    .z           (Z),
    .ctrl        (ctrl)
  );

  assign ir_sclr    = ctrl.ir_sclr;
  assign mar_sclr   = ctrl.mar_sclr;
  assign enaf       = ctrl.enaf;
  assign selop      = ctrl.selop;
  assign shamt      = ctrl.shamt;
  assign bank_wr_en = ctrl.bank_wr_en;
  assign busB_addr  = ctrl.busB_addr;
  assign busC_addr  = ctrl.busC_addr;
  assign ir_en      = ctrl.ir_en;
  assign mar_en     = ctrl.mar_en;
  assign mdr_en     = ctrl.mdr_en;
  assign wr_rdn     = ctrl.wr_rdn;
  assign mdr_alu_n  = ctrl.mdr_alu_n;
  assign halted     = ctrl.halted;
  assign illegal    = ctrl.illegal;

endmodule

// File: tb/tb_control_unit.sv
// Directed bench: control_unit driving a small behavioural memory_system model.
module tb_control_unit;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [4:0] instruction;
  logic       C, N, P, Z;
  logic       ir_sclr, mar_sclr, enaf, bank_wr_en, ir_en, mar_en, mdr_en;
  logic       wr_rdn, mdr_alu_n, halted, illegal;
  logic [2:0] selop, busB_addr, busC_addr;
  logic [1:0] shamt;

  control_unit #(.OPC_W(5), .RST_FETCH(1'b1)) dut (
    .clk(clk), .rst(rst), .start(start), .instruction(instruction),
    .C(C), .N(N), .P(P), .Z(Z),
    .ir_sclr(ir_sclr), .mar_sclr(mar_sclr), .enaf(enaf), .selop(selop),
    .shamt(shamt), .bank_wr_en(bank_wr_en), .busB_addr(busB_addr),
    .busC_addr(busC_addr), .ir_en(ir_en), .mar_en(mar_en), .mdr_en(mdr_en),
    .wr_rdn(wr_rdn), .mdr_alu_n(mdr_alu_n), .halted(halted), .illegal(illegal)
  );

  always #5 clk = ~clk;

  // datapath model
  logic [7:0] mem [256];
  logic [7:0] bank [8];
  logic [7:0] ir_q, mar_q, mdr_q, bus_b, acc, alu_y;
  logic       alu_c;

  always_comb begin
    bus_b = bank[busB_addr];
    acc   = bank[7];
    alu_c = 1'b0;
    alu_y = bus_b;
    case (selop)
      3'd1: {alu_c, alu_y} = {1'b0, acc} + {1'b0, bus_b};
      3'd2: {alu_c, alu_y} = {1'b0, acc} - {1'b0, bus_b};
      3'd3: alu_y = acc & bus_b;
      3'd4: alu_y = acc | bus_b;
      3'd5: alu_y = bus_b << shamt;
      3'd6: alu_y = bus_b + 8'd1;
      3'd7: alu_y = bus_b - 8'd1;
      default: alu_y = bus_b;
    endcase
  end

  // MDR takes the ALU only for the store step, the one MDR load with bus B on ACC
  always @(posedge clk) begin
    if (ir_sclr) ir_q <= 8'h00;
    else if (ir_en) ir_q <= mdr_q;
    if (mar_sclr) mar_q <= 8'h00;
    else if (mar_en) mar_q <= mdr_alu_n ? mdr_q : bus_b;
    if (mdr_en) mdr_q <= (busB_addr == 3'd7) ? alu_y : mem[mar_q];
    if (bank_wr_en) bank[busC_addr] <= mdr_alu_n ? mdr_q : alu_y;
    if (wr_rdn) mem[mar_q] <= mdr_q;
    if (enaf) begin
      Z <= (alu_y == 8'h00);
      C <= alu_c;
      N <= alu_y[7];
      P <= ~^alu_y;
    end
  end

  assign instruction = ir_q[4:0];

  int n_wr = 0, n_bw = 0, n_ill = 0;
  always @(negedge clk) begin
    if (wr_rdn) n_wr <= n_wr + 1;
    if (bank_wr_en) n_bw <= n_bw + 1;
    if (illegal) n_ill <= n_ill + 1;
  end

  int n_tests = 0, n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  function automatic logic [21:0] cw_now();
    return {ir_sclr, mar_sclr, enaf, bank_wr_en, ir_en, mar_en, mdr_en,
            wr_rdn, mdr_alu_n, halted, illegal, selop, shamt, busB_addr, busC_addr};
  endfunction

  task automatic reset_and_clear();
    rst = 1'b1;
    tick(2);
    for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
    for (int i = 0; i < 8; i++) bank[i] <= 8'h00;
    {C, N, P, Z} <= 4'b0000;
  endtask

  // strobe order: ir_sclr mar_sclr enaf bank_wr_en ir_en mar_en mdr_en wr_rdn mdr_alu_n halted illegal
  logic [21:0] exp_ld [10];
  int wr0, bw0, ill0;

  initial begin
    exp_ld[0] = {11'b11000000000, 3'd0, 2'd0, 3'd0, 3'd0};
    exp_ld[1] = {11'b00000100000, 3'd0, 2'd0, 3'd0, 3'd0};
    exp_ld[2] = {11'b00010010000, 3'd6, 2'd0, 3'd0, 3'd0};
    exp_ld[3] = {11'b00001000000, 3'd0, 2'd0, 3'd0, 3'd0};
    exp_ld[4] = {11'b00000000000, 3'd0, 2'd0, 3'd0, 3'd0};
    exp_ld[5] = {11'b00000100000, 3'd0, 2'd0, 3'd0, 3'd0};
    exp_ld[6] = {11'b00010010000, 3'd6, 2'd0, 3'd0, 3'd0};
    exp_ld[7] = {11'b00000100100, 3'd0, 2'd0, 3'd0, 3'd0};
    exp_ld[8] = {11'b00000010000, 3'd0, 2'd0, 3'd0, 3'd0};
    exp_ld[9] = {11'b00010000100, 3'd0, 2'd0, 3'd0, 3'd7};

    // MOV ACC,[0x20] with per-cycle strobes
    reset_and_clear();
    mem[0] <= 8'h01; mem[1] <= 8'h20; mem[8'h20] <= 8'h5A;
    #1 rst = 1'b0;
    check("ld_cw0", 32'(cw_now()), 32'(exp_ld[0]));
    for (int i = 1; i < 10; i++) begin
      tick(1);
      check($sformatf("ld_cw%0d", i), 32'(cw_now()), 32'(exp_ld[i]));
    end
    tick(1);
    check("ld_acc", 32'(bank[7]), 32'h5A);
    check("ld_pc", 32'(bank[0]), 32'h02);

    // MOV #3, ADD A(0xFD), JZ 0x40; start held high outside HALT
    reset_and_clear();
    mem[0] <= 8'h03; mem[1] <= 8'h03; mem[2] <= 8'h04; mem[3] <= 8'h08; mem[4] <= 8'h40;
    bank[2] <= 8'hFD;
    #1 rst = 1'b0;
    start = 1'b1;
    tick(8);
    check("imm_acc", 32'(bank[7]), 32'h03);
    tick(5);
    check("add_acc", 32'(bank[7]), 32'h00);
    check("add_z", 32'(Z), 32'h1);
    check("add_c", 32'(C), 32'h1);
    check("add_pc", 32'(bank[0]), 32'h03);
    tick(7);
    check("jz_taken_pc", 32'(bank[0]), 32'h40);
    start = 1'b0;

    // JZ not taken (Z=0), then JC taken (C=1)
    reset_and_clear();
    mem[0] <= 8'h08; mem[1] <= 8'h40; mem[2] <= 8'h09; mem[3] <= 8'h50;
    C <= 1'b1;
    #1 rst = 1'b0;
    bw0 = n_bw;
    tick(8);
    check("jz_nt_pc", 32'(bank[0]), 32'h02);
    check("jz_nt_bankwr", 32'(n_bw - bw0), 32'd2);
    tick(7);
    check("jc_taken_pc", 32'(bank[0]), 32'h50);

    // MOV [0x30],ACC
    reset_and_clear();
    mem[0] <= 8'h02; mem[1] <= 8'h30;
    bank[7] <= 8'hA5;
    #1 rst = 1'b0;
    wr0 = n_wr;
    tick(10);
    check("st_mem", 32'(mem[8'h30]), 32'hA5);
    check("st_wr_cycles", 32'(n_wr - wr0), 32'd1);

    // illegal opcode 10101, HALT, then start resumes with a NOP
    reset_and_clear();
    mem[0] <= 8'h15; mem[1] <= 8'h1F; mem[2] <= 8'h00;
    #1 rst = 1'b0;
    ill0 = n_ill;
    tick(5);
    check("ill_pulses", 32'(n_ill - ill0), 32'd1);
    check("ill_pc", 32'(bank[0]), 32'h01);
    tick(4);
    check("halt_on", 32'(halted), 32'h1);
    check("halt_pc", 32'(bank[0]), 32'h02);
    tick(5);
    check("halt_hold", 32'(cw_now()), 32'({11'b00000000010, 11'd0}));
    start = 1'b1;
    tick(1);
    start = 1'b0;
    check("start_leaves", 32'(halted), 32'h0);
    tick(4);
    check("resume_pc", 32'(bank[0]), 32'h03);
    check("resume_ill", 32'(n_ill - ill0), 32'd1);

    // reset during E3 of a store
    reset_and_clear();
    mem[0] <= 8'h02; mem[1] <= 8'h30;
    bank[7] <= 8'hA5;
    #1 rst = 1'b0;
    wr0 = n_wr;
    tick(8);
    check("pre_abort_cw", 32'(cw_now()), 32'({11'b00000010000, 3'd0, 2'd0, 3'd7, 3'd0}));
    #1 rst = 1'b1;
    #1 check("abort_cw", 32'(cw_now()), 32'(exp_ld[0]));
    tick(3);
    check("abort_mem", 32'(mem[8'h30]), 32'h00);
    check("abort_wr", 32'(n_wr - wr0), 32'd0);
    rst = 1'b0;
    check("restart_init", 32'(cw_now()), 32'(exp_ld[0]));
    tick(1);
    check("restart_f0", 32'(cw_now()), 32'(exp_ld[1]));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
